// File: rtl/bus_generator_arbiter_pkg.sv
// Shared types and helpers for the shared-bus generator/arbiter.
// Holds the per-bus FSM state and field-width helper functions.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        PUSH
    } state_t;

    function automatic int id_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_generator_arbiter_if.sv
// Agent-side bundle of the shared-bus arbiter.
// Master is the arbiter; slave is the agent FIFO side.
interface bus_generator_arbiter_if #(
    parameter int bits    = 1,
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
);

    logic [bits-1:0][drvrs-1:0]              pndng;
    logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
    logic [bits-1:0][drvrs-1:0]              pop;
    logic [bits-1:0][drvrs-1:0]              push;
    logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push;

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push
    );

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push
    );

endinterface

// File: rtl/bus_generator_arbiter_rr.sv
// Combinational round-robin pick: first request at or after ptr.
// any is low when no request is set; idx is then 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] idx
);

    int c;

    always_comb begin
        any = 1'b0;
        idx = '0;
        c   = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                any = 1'b1;
                idx = PW'(c);
            end
        end
    end

endmodule

// File: rtl/bus_generator_arbiter.sv
// Round-robin shared-bus generator: pops one packet per grant
// and pushes it to its decoded destination or broadcasts it.
module bus_generator_arbiter
    import bus_arb_pkg::*;
#(
    parameter int bits    = 1,
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16,
    parameter int ID_W    = id_w(drvrs),
    parameter logic [ID_W-1:0] broadcast = '1
) (
    input  logic clk,
    input  logic reset,
    bus_generator_arbiter_if.master bus
);

    localparam int PW = ptr_w(drvrs);
    localparam logic [drvrs-1:0] ONE = drvrs'(1);

    for (genvar b = 0; b < bits; b++) begin : g_bus

        state_t             st;
        logic [PW-1:0]      src;
        logic [PW-1:0]      rr;
        logic [PW-1:0]      gnt;
        logic               any;
        logic [pckg_sz-1:0] pkt;
        logic [ID_W-1:0]    dst;
        logic [drvrs-1:0]   dec;
        logic [drvrs-1:0]   pop_q;
        logic [drvrs-1:0]   push_q;
        logic [pckg_sz-1:0] dp_q;

        rr_arbiter #(
            .N  (drvrs),
            .PW (PW)
        ) u_rr (
            .req (bus.pndng[b]),
            .ptr (rr),
            .any (any),
            .idx (gnt)
        );

        assign pkt = bus.D_pop[b][src];
        assign dst = pkt[pckg_sz-1 -: ID_W];

        // Unknown destinations fall through with no push: the packet is dropped.
        always_comb begin
            dec = '0;
            if (dst == broadcast) begin
                dec = ~(ONE << src);
            end else if (32'(dst) < 32'(drvrs)) begin
                dec = ONE << dst;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st     <= IDLE;
                src    <= '0;
                rr     <= '0;
                pop_q  <= '0;
                push_q <= '0;
                dp_q   <= '0;
            end else begin
                unique case (st)
                    IDLE: begin
                        push_q <= '0;
                        if (any) begin
                            src   <= gnt;
                            pop_q <= ONE << gnt;
                            st    <= POP;
                        end
                    end
                    POP: begin
                        pop_q  <= '0;
                        push_q <= dec;
                        dp_q   <= pkt;
                        st     <= PUSH;
                    end
                    PUSH: begin
                        push_q <= '0;
                        rr     <= (src == PW'(drvrs - 1)) ? '0 : src + 1'b1;
                        st     <= IDLE;
                    end
                    default: begin
                        pop_q  <= '0;
                        push_q <= '0;
                        st     <= IDLE;
                    end
                endcase
            end
        end

        assign bus.pop[b]  = pop_q;
        assign bus.push[b] = push_q;
        for (genvar i = 0; i < drvrs; i++) begin : g_dp
            assign bus.D_push[b][i] = dp_q;
        end

    end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Bench for bus_generator_arbiter: directed cases on an 8-agent bus
// and randomized traffic on a 2x4-agent instance against a model.
module tb_bus_generator_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bus_generator_arbiter_if #(.bits(1), .drvrs(8), .pckg_sz(4))  if8 ();
    bus_generator_arbiter_if #(.bits(2), .drvrs(4), .pckg_sz(16)) if4 ();

    bus_generator_arbiter #(.bits(1), .drvrs(8), .pckg_sz(4)) u8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    bus_generator_arbiter #(.bits(2), .drvrs(4), .pckg_sz(16)) u4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_pop8"},  64'(if8.pop),       64'h0);
        check({tag, "_push8"}, 64'(if8.push),      64'h0);
        check({tag, "_dp8"},   64'(if8.D_push),    64'h0);
        check({tag, "_pop4"},  64'(if4.pop),       64'h0);
        check({tag, "_push4"}, 64'(if4.push),      64'h0);
        check({tag, "_dp4a"},  64'(if4.D_push[0]), 64'h0);
        check({tag, "_dp4b"},  64'(if4.D_push[1]), 64'h0);
    endtask

    task automatic rand_inputs();
        if8.pndng = 8'($urandom);
        for (int i = 0; i < 8; i++) if8.D_pop[0][i] = 4'($urandom);
        for (int b = 0; b < 2; b++) begin
            if4.pndng[b] = 4'($urandom);
            for (int i = 0; i < 4; i++) if4.D_pop[b][i] = 16'($urandom);
        end
    endtask

    // Transaction-level reference for the 2x4 instance
    int          free_at[2];
    int          rr_m[2];
    int          psrc[2];
    int          pedge[2];
    logic [15:0] dp_m[2];
    logic [3:0]  epop[2];
    logic [3:0]  epush[2];
    logic [15:0] pkt;
    int          g;
    int          dst;
    logic [7:0]  rr_order[4];

    initial begin
        reset = 1'b0;
        rand_inputs();

        // Reset held with random pending traffic
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rand_inputs();
            @(posedge clk);
            #1;
            all_zero("rst");
        end

        @(negedge clk);
        reset = 1'b1;
        if8.pndng = '0;
        if4.pndng = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            all_zero("idle");
        end

        // Round robin on agents 0, 4, 7; packets carry an invalid id
        rr_order[0] = 8'h01;
        rr_order[1] = 8'h10;
        rr_order[2] = 8'h80;
        rr_order[3] = 8'h01;
        @(negedge clk);
        if8.pndng = 8'h91;
        for (int i = 0; i < 8; i++) if8.D_pop[0][i] = 4'h9;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            check("rr_pop", 64'(if8.pop), (c % 3 == 0) ? 64'(rr_order[c / 3]) : 64'h0);
            check("rr_push", 64'(if8.push), 64'h0);
        end
        @(negedge clk);
        if8.pndng = '0;
        repeat (2) @(posedge clk);

        // Unicast 2 -> 5
        @(negedge clk);
        if8.pndng = 8'h04;
        if8.D_pop[0][2] = 4'h5;
        @(posedge clk);
        #1;
        check("uni_pop", 64'(if8.pop), 64'h04);
        check("uni_push0", 64'(if8.push), 64'h0);
        @(negedge clk);
        if8.pndng = '0;
        @(posedge clk);
        #1;
        check("uni_pop_off", 64'(if8.pop), 64'h0);
        check("uni_push", 64'(if8.push), 64'h20);
        check("uni_dp", 64'(if8.D_push), 64'h5555_5555);
        @(posedge clk);
        #1;
        check("uni_push_off", 64'(if8.push), 64'h0);
        check("uni_dp_hold", 64'(if8.D_push), 64'h5555_5555);

        // Broadcast from agent 3
        @(negedge clk);
        if8.pndng = 8'h08;
        if8.D_pop[0][3] = 4'hF;
        @(posedge clk);
        #1;
        check("bc_pop", 64'(if8.pop), 64'h08);
        @(negedge clk);
        if8.pndng = '0;
        @(posedge clk);
        #1;
        check("bc_push", 64'(if8.push), 64'hF7);
        check("bc_dp", 64'(if8.D_push), 64'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("bc_push_off", 64'(if8.push), 64'h0);

        // Randomized traffic on both 4-agent buses
        for (int b = 0; b < 2; b++) begin
            free_at[b] = 0;
            rr_m[b]    = 0;
            psrc[b]    = 0;
            pedge[b]   = -1;
            dp_m[b]    = '0;
        end
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            for (int b = 0; b < 2; b++) begin
                if4.pndng[b] = 4'($urandom_range(0, 15));
                for (int i = 0; i < 4; i++) if4.D_pop[b][i] = 16'($urandom);
            end
            for (int b = 0; b < 2; b++) begin
                epop[b]  = '0;
                epush[b] = '0;
                if (pedge[b] == t) begin
                    pkt = if4.D_pop[b][psrc[b]];
                    dst = int'(pkt[15:13]);
                    if (dst == 7) epush[b] = 4'hF & ~(4'b1 << psrc[b]);
                    else if (dst < 4) epush[b] = 4'b1 << dst;
                    dp_m[b] = pkt;
                end
                if (t >= free_at[b] && if4.pndng[b] != 4'h0) begin
                    g = -1;
                    for (int k = 0; k < 4; k++)
                        if (g < 0 && if4.pndng[b][(rr_m[b] + k) % 4]) g = (rr_m[b] + k) % 4;
                    epop[b]    = 4'b1 << g;
                    psrc[b]    = g;
                    pedge[b]   = t + 1;
                    free_at[b] = t + 3;
                    rr_m[b]    = (g + 1) % 4;
                end
            end
            @(posedge clk);
            #1;
            for (int b = 0; b < 2; b++) begin
                check("rand_pop", 64'(if4.pop[b]), 64'(epop[b]));
                check("rand_push", 64'(if4.push[b]), 64'(epush[b]));
                check("rand_dp", 64'(if4.D_push[b]), {4{dp_m[b]}});
            end
        end
        @(negedge clk);
        if4.pndng = '0;
        repeat (4) @(posedge clk);

        // Invalid destination id 5 on bus 0
        @(negedge clk);
        if4.pndng[0] = 4'b0010;
        if4.D_pop[0][1] = {3'd5, 13'h0abc};
        @(posedge clk);
        #1;
        check("inv_pop", 64'(if4.pop[0]), 64'h2);
        @(negedge clk);
        if4.pndng = '0;
        @(posedge clk);
        #1;
        check("inv_pop_off", 64'(if4.pop[0]), 64'h0);
        check("inv_push", 64'(if4.push[0]), 64'h0);
        @(posedge clk);
        #1;
        check("inv_push2", 64'(if4.push[0]), 64'h0);
        @(negedge clk);
        if4.pndng[0] = 4'b0001;
        @(posedge clk);
        #1;
        check("inv_back_idle", 64'(if4.pop[0]), 64'h1);
        @(negedge clk);
        if4.pndng = '0;

        // Reset during POP, then restart from agent 0
        @(negedge clk);
        if8.pndng = 8'h22;
        @(posedge clk);
        #1;
        check("rp_pop", 64'(if8.pop), 64'h20);
        #2;
        reset = 1'b0;
        #1;
        check("rp_async_pop", 64'(if8.pop), 64'h0);
        check("rp_async_push", 64'(if8.push), 64'h0);
        check("rp_async_dp", 64'(if8.D_push), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rp_restart", 64'(if8.pop), 64'h02);
        @(negedge clk);
        if8.pndng = '0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
